// File: rtl/uart_pkg.sv
// +------------------------------------------------------------------+
// | uart_pkg : shared constants and types for the UART tx/rx cores   |
// | Rev 1.0  : initial release                                       |
// +------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [4:0] {
    IDLE      = 5'b0_0001,
    STARTBIT  = 5'b0_0010,
    DATABITS  = 5'b0_0100,
    PARITYBIT = 5'b0_1000,
    STOPBIT   = 5'b1_0000
  } state_t;

  localparam logic ENABLE   = 1'b1;
  localparam logic DISABLE  = 1'b0;
  localparam logic EMPTY    = 1'b1;
  localparam logic NONEMPTY = 1'b0;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tmr_vote.sv
// +------------------------------------------------------------------+
// | tmr_vote : bitwise 2-of-3 majority voter for TMR registers       |
// | Rev 1.0  : initial release                                       |
// +------------------------------------------------------------------+
`default_nettype none

module tmr_vote #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

`default_nettype wire

// File: rtl/rx_fsm.sv
// +------------------------------------------------------------------+
// | rx_fsm : UART receive FSM, 3-sample mid-bit vote, TMR state      |
// | Rev 1.0  : initial release                                       |
// +------------------------------------------------------------------+
`default_nettype none

module rx_fsm
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       p_SampleTick_i,
  input  logic       Rx_i,
  input  logic       ParityEnable_i,
  input  logic       ParityOdd_i,
  output logic [4:0] State_o,
  output logic [3:0] BitCounter_o,
  output logic [7:0] Data_o,
  output logic       p_ByteValid_o,
  output logic       p_ParityErr_o,
  output logic       p_FrameErr_o
);

  localparam int MID = OVERSAMPLE / 2;

  logic                 rx_meta_q, rx_s_q;
  logic [4:0]           state0_q, state1_q, state2_q;
  logic [3:0]           bitcnt0_q, bitcnt1_q, bitcnt2_q;
  logic [3:0]           smpcnt0_q, smpcnt1_q, smpcnt2_q;
  logic                 smp0_q, smp1_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_en_q, par_odd_q, par_err_q;
  logic [7:0]           data_q;
  logic                 valid_q, perr_q, ferr_q;

  logic [4:0]           w_state;
  logic [3:0]           w_bitcnt, w_smpcnt;
  logic [3:0]           w_cnt_next;
  logic                 w_legal, w_voted, w_bit_end, w_mid_m1, w_mid, w_mid_p1;

  logic [4:0]           state_d;
  logic [3:0]           bitcnt_d, smpcnt_d;
  logic                 smp0_d, smp1_d;
  logic [DATA_BITS-1:0] shift_d;
  logic                 par_en_d, par_odd_d, par_err_d;
  logic [7:0]           data_d;
  logic                 valid_d, perr_d, ferr_d;

  tmr_vote #(.WIDTH(5)) u_vote_state (
    .a_i(state0_q), .b_i(state1_q), .c_i(state2_q), .y_o(w_state)
  );
  tmr_vote #(.WIDTH(4)) u_vote_bitcnt (
    .a_i(bitcnt0_q), .b_i(bitcnt1_q), .c_i(bitcnt2_q), .y_o(w_bitcnt)
  );
  tmr_vote #(.WIDTH(4)) u_vote_smpcnt (
    .a_i(smpcnt0_q), .b_i(smpcnt1_q), .c_i(smpcnt2_q), .y_o(w_smpcnt)
  );

  // The sample counter register holds the count of the last tick, so the
  // count belonging to the current tick is one ahead of it.
  assign w_cnt_next = (w_smpcnt == 4'(OVERSAMPLE - 1)) ? 4'd0 : w_smpcnt + 4'd1;
  assign w_bit_end  = (w_cnt_next == 4'(OVERSAMPLE - 1));
  assign w_mid_m1   = (w_cnt_next == 4'(MID - 1));
  assign w_mid      = (w_cnt_next == 4'(MID));
  assign w_mid_p1   = (w_cnt_next == 4'(MID + 1));
  assign w_voted    = maj3(smp0_q, smp1_q, rx_s_q);
  assign w_legal    = (w_state == IDLE) || (w_state == STARTBIT) || (w_state == DATABITS) ||
                      (w_state == PARITYBIT) || (w_state == STOPBIT);

  always_comb begin
    state_d   = w_state;
    bitcnt_d  = '0;
    smpcnt_d  = w_cnt_next;
    smp0_d    = w_mid_m1 ? rx_s_q : smp0_q;
    smp1_d    = w_mid    ? rx_s_q : smp1_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    par_err_d = par_err_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    case (w_state)
      IDLE: begin
        smpcnt_d = '0;
        if (!rx_s_q) begin
          state_d   = STARTBIT;
          par_en_d  = ParityEnable_i;
          par_odd_d = ParityOdd_i;
        end
      end
      STARTBIT: begin
        if (w_mid_p1 && w_voted) begin
          state_d  = IDLE;
          smpcnt_d = '0;
        end else if (w_bit_end) begin
          state_d = DATABITS;
        end
      end
      DATABITS: begin
        bitcnt_d = w_bitcnt;
        if (w_mid_p1) shift_d = {w_voted, shift_q[DATA_BITS-1:1]};
        if (w_bit_end) begin
          if (w_bitcnt == 4'(DATA_BITS - 1)) begin
            state_d  = (par_en_q == ENABLE) ? PARITYBIT : STOPBIT;
            bitcnt_d = '0;
          end else begin
            bitcnt_d = w_bitcnt + 4'd1;
          end
        end
      end
      PARITYBIT: begin
        if (w_mid_p1) par_err_d = w_voted ^ (^shift_q) ^ par_odd_q;
        if (w_bit_end) state_d = STOPBIT;
      end
      STOPBIT: begin
        // Decide at mid-bit and drop to IDLE so a back-to-back start is seen.
        if (w_mid_p1) begin
          data_d                 = '0;
          data_d[DATA_BITS-1:0]  = shift_q;
          valid_d                = 1'b1;
          ferr_d                 = ~w_voted;
          perr_d                 = par_err_q & par_en_q;
          state_d                = IDLE;
          smpcnt_d               = '0;
        end
      end
      default: begin
        state_d  = IDLE;
        smpcnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state0_q  <= IDLE;
      state1_q  <= IDLE;
      state2_q  <= IDLE;
      bitcnt0_q <= '0;
      bitcnt1_q <= '0;
      bitcnt2_q <= '0;
      smpcnt0_q <= '0;
      smpcnt1_q <= '0;
      smpcnt2_q <= '0;
      smp0_q    <= 1'b1;
      smp1_q    <= 1'b1;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      par_err_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= Rx_i;
      rx_s_q    <= rx_meta_q;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      if (!w_legal) begin
        state0_q  <= IDLE;
        state1_q  <= IDLE;
        state2_q  <= IDLE;
        bitcnt0_q <= '0;
        bitcnt1_q <= '0;
        bitcnt2_q <= '0;
        smpcnt0_q <= '0;
        smpcnt1_q <= '0;
        smpcnt2_q <= '0;
      end else if (p_SampleTick_i) begin
        state0_q  <= state_d;
        state1_q  <= state_d;
        state2_q  <= state_d;
        bitcnt0_q <= bitcnt_d;
        bitcnt1_q <= bitcnt_d;
        bitcnt2_q <= bitcnt_d;
        smpcnt0_q <= smpcnt_d;
        smpcnt1_q <= smpcnt_d;
        smpcnt2_q <= smpcnt_d;
        smp0_q    <= smp0_d;
        smp1_q    <= smp1_d;
        shift_q   <= shift_d;
        par_en_q  <= par_en_d;
        par_odd_q <= par_odd_d;
        par_err_q <= par_err_d;
        data_q    <= data_d;
        valid_q   <= valid_d;
        perr_q    <= perr_d;
        ferr_q    <= ferr_d;
      end
    end
  end

  assign State_o       = w_state;
  assign BitCounter_o  = w_bitcnt;
  assign Data_o        = data_q;
  assign p_ByteValid_o = valid_q;
  assign p_ParityErr_o = perr_q;
  assign p_FrameErr_o  = ferr_q;

endmodule

`default_nettype wire
